// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline hazard/sequencing control.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        MEM_ABORT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// EX-stage forwarding source selector for one source operand.
// EX/MEM wins over MEM/WB because it holds the younger result; x0 never forwards.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == ex_rs);
    assign hit_wb  = wb_regwrite  && (wb_rd  != REG_ZERO) && (wb_rd  == ex_rs);

    always_comb begin
        fwd = FWD_RF;
        if (hit_mem) begin
            fwd = FWD_EXMEM;
        end else if (hit_wb) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/forward control plus the data-memory wait/timeout FSM.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        ex_rs1,
    input  logic [4:0]        ex_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic [4:0]        mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_access,
    input  logic [4:0]        wb_rd,
    input  logic              wb_regwrite,
    input  logic              dmem_ready,
    input  logic              err_clr,
    output logic              dmem_req,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic            load_use;
    logic            freeze;
    logic            abort;
    logic            hazard_ok;
    logic            req;
    logic            branch_flush;
    logic            load_use_hold;
    logic [1:0]      fwd_a_raw;
    logic [1:0]      fwd_b_raw;

    assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // hazard_ok marks cycles where the whole pipeline advances, so branch and
    // load-use handling apply; this includes the MEM_WAIT release cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze     = 1'b0;
        abort      = 1'b0;
        hazard_ok  = 1'b0;
        req        = 1'b0;
        unique case (state_q)
            RUN: begin
                req = mem_access;
                if (mem_access && !dmem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end else begin
                    hazard_ok = 1'b1;
                end
            end
            MEM_WAIT: begin
                req = mem_access;
                if (dmem_ready) begin
                    hazard_ok  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                        state_d = MEM_ABORT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                end
            end
            MEM_ABORT: begin
                abort      = 1'b1;
                state_d    = RUN;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (err_clr) begin
            mem_err_d = 1'b0;
        end
        if (abort) begin
            mem_err_d = 1'b1;
        end
    end

    assign branch_flush  = hazard_ok && ex_branch_taken;
    assign load_use_hold = hazard_ok && !ex_branch_taken && load_use;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    fwd_sel u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_raw)
    );

    // Every output is forced low while reset is held, including the combinational ones.
    assign dmem_req     = rstn && req;
    assign pc_stall     = rstn && (freeze || abort || load_use_hold);
    assign if_id_stall  = rstn && (freeze || abort || load_use_hold);
    assign id_ex_stall  = rstn && (freeze || abort);
    assign ex_mem_stall = rstn && freeze;
    assign if_id_flush  = rstn && branch_flush;
    assign id_ex_flush  = rstn && (branch_flush || load_use_hold);
    assign ex_mem_flush = rstn && abort;
    assign mem_wb_flush = rstn && (freeze || abort);
    assign forward_a    = rstn ? fwd_a_raw : FWD_RF;
    assign forward_b    = rstn ? fwd_b_raw : FWD_RF;
    assign mem_err      = rstn && mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
        if (if_id_flush || ex_mem_flush) begin
            flush_events_d = flush_events_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_memread, ex_branch_taken, mem_regwrite, mem_access;
    logic        wb_regwrite, dmem_ready, err_clr;
    logic        dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0]  forward_a, forward_b;
    logic        mem_err;
    logic [31:0] stall_cycles, flush_events;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: m_wait = 0 running, 1..TMO waiting cycle number, -1 abort cycle.
    int          m_wait;
    bit          m_err;
    logic [31:0] m_stalls, m_flushes;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(8), .PERF_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_ready(dmem_ready),
        .err_clr(err_clr), .dmem_req(dmem_req),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .forward_a(forward_a), .forward_b(forward_b),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_regwrite && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [8:0] ctl_vec();
        return {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    task automatic model_reset();
        m_wait    = 0;
        m_err     = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Inputs are set by the caller just after a negedge; check, clock, advance model.
    task automatic step();
        bit blocked, aborting, advancing, lu, br, lu_hold;
        bit e_req, e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_exf, e_wbf;
        #1;
        aborting  = (m_wait < 0);
        blocked   = ((m_wait == 0) && mem_access && !dmem_ready) || ((m_wait > 0) && !dmem_ready);
        advancing = !aborting && !blocked;
        lu        = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        br        = advancing && ex_branch_taken;
        lu_hold   = advancing && !ex_branch_taken && lu;
        e_req = !aborting && mem_access;
        e_pc  = blocked || aborting || lu_hold;
        e_ifs = e_pc;
        e_ids = blocked || aborting;
        e_exs = blocked;
        e_iff = br;
        e_idf = br || lu_hold;
        e_exf = aborting;
        e_wbf = blocked || aborting;
        chk("ctl", 32'(ctl_vec()),
            32'({e_req, e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_exf, e_wbf}));
        chk("fwd", 32'({forward_a, forward_b}), 32'({fwd_ref(ex_rs1), fwd_ref(ex_rs2)}));
        chk("mem_err", 32'(mem_err), 32'(m_err));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("flush_events", flush_events, m_flushes);
`else
        chk("perf_off", stall_cycles | flush_events, 32'd0);
`endif
        @(posedge clk);
        if (e_pc) m_stalls++;
        if (e_iff || e_exf) m_flushes++;
        if (err_clr) m_err = 0;
        if (aborting) begin
            m_err  = 1;
            m_wait = 0;
        end else if (m_wait == 0) begin
            if (mem_access && !dmem_ready) m_wait = 1;
        end else if (dmem_ready) begin
            m_wait = 0;
        end else if (m_wait == TMO) begin
            m_wait = -1;
        end else begin
            m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_regwrite = 0; wb_regwrite = 0; mem_access = 0; dmem_ready = 1;
        err_clr = 0;
    endtask

    task automatic randomize_inputs(input int rdy_pct);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
        wb_rd  = 5'($urandom_range(0, 3));
        ex_memread      = ($urandom_range(0, 99) < 35);
        ex_branch_taken = ($urandom_range(0, 99) < 20);
        mem_regwrite    = ($urandom_range(0, 99) < 60);
        wb_regwrite     = ($urandom_range(0, 99) < 60);
        mem_access      = ($urandom_range(0, 99) < 40);
        dmem_ready      = ($urandom_range(0, 99) < rdy_pct);
        err_clr         = ($urandom_range(0, 99) < 10);
    endtask

    task automatic all_zero(input string tag);
        chk(tag, 32'({ctl_vec(), forward_a, forward_b, mem_err}), 32'd0);
        chk({tag, "_perf"}, stall_cycles | flush_events, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        randomize_inputs(50);
        mem_access = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3;
        mem_regwrite = 1; mem_rd = 2; ex_rs1 = 2;
        model_reset();
        repeat (2) @(negedge clk);
        all_zero("reset");
        rstn = 1'b1;
        quiet();

        // Load-use, then the same with ex_rd = x0.
        ex_memread = 1; ex_rd = 5; id_rs2 = 5;
        #1 chk("lu_stall", 32'({pc_stall, if_id_stall, id_ex_flush}), 32'b111);
        step();
        quiet();
        #1 chk("lu_one_cycle", 32'(pc_stall), 32'd0);
        step();
        ex_memread = 1; ex_rd = 0; id_rs2 = 0;
        #1 chk("lu_x0", 32'(pc_stall), 32'd0);
        step();

        // Branch together with load-use.
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1;
        #1 chk("br_over_lu", 32'({if_id_flush, id_ex_flush, pc_stall}), 32'b110);
        step();
        quiet();

        // Memory wait: ready low three cycles, then high.
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("wait_frz", 32'({pc_stall, ex_mem_stall, mem_wb_flush}), 32'b111);
            step();
        end
        dmem_ready = 1;
        #1 chk("wait_rel", 32'({pc_stall, ex_mem_stall, mem_wb_flush, dmem_req}), 32'b0001);
        step();
        mem_access = 0;
        #1 chk("back_run", 32'(pc_stall), 32'd0);
        step();

        // Timeout: one RUN freeze cycle plus TMO wait cycles, then the abort cycle.
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < TMO + 1; i++) step();
        #1 chk("abort", 32'({ex_mem_flush, dmem_req, ex_mem_stall, pc_stall}), 32'b1001);
        step();
        quiet();
        step();
        #1 chk("err_sticky", 32'(mem_err), 32'd1);
        err_clr = 1;
        step();
        err_clr = 0;
        #1 chk("err_clr", 32'(mem_err), 32'd0);
        step();

        // Forwarding priority and x0.
        mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1; ex_rs1 = 7;
        #1 chk("fwd_exmem", 32'(forward_a), 32'b10);
        step();
        mem_regwrite = 0;
        #1 chk("fwd_memwb", 32'(forward_a), 32'b01);
        step();
        ex_rs1 = 0; mem_regwrite = 1; mem_rd = 0; wb_rd = 0;
        #1 chk("fwd_x0", 32'(forward_a), 32'b00);
        step();
        quiet();

        // Random traffic with varying memory readiness.
        for (int blk = 0; blk < 30; blk++) begin
            int pct;
            pct = (blk % 3 == 0) ? 5 : 65;
            for (int i = 0; i < 40; i++) begin
                randomize_inputs(pct);
                step();
            end
        end

        // Async reset in the middle of a memory wait.
        quiet();
        dmem_ready = 1; step(); step();
        mem_access = 1; dmem_ready = 0;
        step(); step();
        #2 rstn = 1'b0;
        #1 all_zero("async_rst");
        model_reset();
        @(negedge clk);
        all_zero("rst_hold");
        rstn = 1'b1;
        quiet();
        #1 chk("after_rst_run", 32'({pc_stall, mem_wb_flush}), 32'd0);
        chk("after_rst_perf", stall_cycles, 32'd0);
        step();
        for (int i = 0; i < 200; i++) begin
            randomize_inputs(60);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
